// File: rtl/nic_pkg.sv
// Shared definitions for the NIC access sequencer:
// register map, FSM states and turn ownership.
package nic_pkg;

   localparam int NIC_DATA_W = 64;

   localparam logic [1:0] NIC_ADDR_IN_BUF   = 2'b00;
   localparam logic [1:0] NIC_ADDR_IN_STAT  = 2'b01;
   localparam logic [1:0] NIC_ADDR_OUT_BUF  = 2'b10;
   localparam logic [1:0] NIC_ADDR_OUT_STAT = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_POLL_OUT = 3'd1,
      S_WRITE    = 3'd2,
      S_POLL_IN  = 3'd3,
      S_READ     = 3'd4
   } nic_state_e;

   typedef enum logic {
      G_RX = 1'b0,
      G_TX = 1'b1
   } nic_grant_e;

endpackage

// File: rtl/nic_tx_fifo.sv
// TX packet queue: synchronous FIFO, combinational head,
// pointers wrap modulo DEPTH (power of two).
module nic_tx_fifo
   import nic_pkg::*;
#(
   parameter int DATA_W = NIC_DATA_W,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_push,
   input  logic [DATA_W-1:0] i_din,
   input  logic              i_pop,
   output logic              o_full,
   output logic              o_empty,
   output logic [DATA_W-1:0] o_head
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [CW-1:0]     r_cnt;

   assign o_full  = (r_cnt == CW'(DEPTH));
   assign o_empty = (r_cnt == '0);
   assign o_head  = r_mem[r_rd_ptr];

   // storage array, written on push only
   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wr_ptr] <= i_din;
   end

   // pointers and occupancy; push+pop keeps the count
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         unique case ({i_push, i_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule

// File: rtl/nic_access_ctrl.sv
// NIC register-port sequencer: round-robin TX/RX turns.
// Optional statistics counters: define NIC_CTRL_STATS_EN.
module nic_access_ctrl
   import nic_pkg::*;
#(
   parameter int DATA_W    = NIC_DATA_W,
   parameter int TXQ_DEPTH = 4,
   parameter int CNT_W     = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              tx_valid,
   input  logic [DATA_W-1:0] tx_data,
   output logic              tx_ready,
   output logic              rx_valid,
   output logic [DATA_W-1:0] rx_data,
   input  logic              rx_ready,
   output logic              nic_en,
   output logic              nic_wr_en,
   output logic [1:0]        nic_addr,
   output logic [DATA_W-1:0] nic_d_in,
   input  logic [DATA_W-1:0] nic_d_out,
   input  logic              nic_buff_en,
   output logic              busy
`ifdef NIC_CTRL_STATS_EN
   ,
   output logic [CNT_W-1:0]  tx_cnt,
   output logic [CNT_W-1:0]  rx_cnt
`endif
);

   if (TXQ_DEPTH < 2 || (TXQ_DEPTH & (TXQ_DEPTH - 1)) != 0
       || CNT_W < 1) begin : g_bad_param
      $error("nic_access_ctrl: illegal parameters");
   end

   nic_state_e        r_state;
   nic_state_e        w_next;
   nic_grant_e        r_last_grant;
   nic_grant_e        w_next_grant;
   logic              r_rx_valid;
   logic [DATA_W-1:0] r_rx_data;
   logic              w_push;
   logic              w_pop;
   logic              w_full;
   logic              w_empty;
   logic [DATA_W-1:0] w_head;
   logic              w_tx_elig;
   logic              w_rx_elig;

   assign tx_ready  = !w_full;
   assign w_push    = tx_valid && !w_full;
   assign w_pop     = (r_state == S_WRITE) && nic_buff_en;
   assign w_tx_elig = !w_empty;
   assign w_rx_elig = !r_rx_valid;
   assign rx_valid  = r_rx_valid;
   assign rx_data   = r_rx_data;
   assign busy      = (r_state != S_IDLE) || !w_empty
                    || r_rx_valid;

   nic_tx_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (TXQ_DEPTH)
   ) u_txq (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_din   (tx_data),
      .i_pop   (w_pop),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_head  (w_head)
   );

   // state and turn-ownership registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_last_grant <= G_RX;
      end else begin
         r_state      <= w_next;
         r_last_grant <= w_next_grant;
      end
   end

   // turn arbitration and access sequencing
   always_comb begin
      w_next       = r_state;
      w_next_grant = r_last_grant;
      unique case (r_state)
         S_IDLE: begin
            if (w_tx_elig &&
                (!w_rx_elig || r_last_grant == G_RX)) begin
               w_next       = S_POLL_OUT;
               w_next_grant = G_TX;
            end else if (w_rx_elig) begin
               w_next       = S_POLL_IN;
               w_next_grant = G_RX;
            end
         end
         S_POLL_OUT:
            w_next = nic_d_out[0] ? S_IDLE : S_WRITE;
         S_WRITE:
            w_next = S_IDLE;
         S_POLL_IN:
            w_next = nic_d_out[0] ? S_READ : S_IDLE;
         S_READ:
            w_next = S_IDLE;
         default:
            w_next = S_IDLE;
      endcase
   end

   // Moore decode of the NIC register port
   always_comb begin
      nic_en    = 1'b0;
      nic_wr_en = 1'b0;
      nic_addr  = 2'b00;
      nic_d_in  = '0;
      unique case (r_state)
         S_POLL_OUT: begin
            nic_en   = 1'b1;
            nic_addr = NIC_ADDR_OUT_STAT;
         end
         S_WRITE: begin
            nic_en    = 1'b1;
            nic_wr_en = 1'b1;
            nic_addr  = NIC_ADDR_OUT_BUF;
            nic_d_in  = w_head;
         end
         S_POLL_IN: begin
            nic_en   = 1'b1;
            nic_addr = NIC_ADDR_IN_STAT;
         end
         S_READ: begin
            nic_en   = 1'b1;
            nic_addr = NIC_ADDR_IN_BUF;
         end
         default: ;
      endcase
   end

   // received packet holding register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rx_valid <= 1'b0;
         r_rx_data  <= '0;
      end else if (r_state == S_READ) begin
         r_rx_valid <= 1'b1;
         r_rx_data  <= nic_d_out;
      end else if (r_rx_valid && rx_ready) begin
         r_rx_valid <= 1'b0;
      end
   end

`ifdef NIC_CTRL_STATS_EN
   logic [CNT_W-1:0] r_tx_cnt;
   logic [CNT_W-1:0] r_rx_cnt;

   assign tx_cnt = r_tx_cnt;
   assign rx_cnt = r_rx_cnt;

   // completed-transfer counters, free-running wrap
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_tx_cnt <= '0;
         r_rx_cnt <= '0;
      end else begin
         if (w_pop)              r_tx_cnt <= r_tx_cnt + 1'b1;
         if (r_state == S_READ)  r_rx_cnt <= r_rx_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_nic_access_ctrl.sv
// Randomized bench for nic_access_ctrl with a
// transaction-level NIC/PE reference model.
module tb_nic_access_ctrl;

   localparam logic [3:0] B_IDLE  = 4'b0000;
   localparam logic [3:0] B_OSTAT = 4'b1011;
   localparam logic [3:0] B_OWR   = 4'b1110;
   localparam logic [3:0] B_ISTAT = 4'b1001;
   localparam logic [3:0] B_IRD   = 4'b1000;
   localparam int         QD      = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        tx_valid;
   logic [63:0] tx_data;
   logic        tx_ready;
   logic        rx_valid;
   logic [63:0] rx_data;
   logic        rx_ready;
   logic        nic_en;
   logic        nic_wr_en;
   logic [1:0]  nic_addr;
   logic [63:0] nic_d_in;
   logic [63:0] nic_d_out;
   logic        nic_buff_en;
   logic        busy;
`ifdef NIC_CTRL_STATS_EN
   logic [31:0] tx_cnt;
   logic [31:0] rx_cnt;
`endif

   // NIC behaviour knobs, redrawn every cycle
   logic        out_busy;
   logic        in_avail;
   logic [63:0] in_data;
   logic        buff_acc;

   int n_total = 0;
   int n_bad   = 0;

   int p_txv, p_busy, p_avail, p_acc, p_rdy;
   bit use_fix = 0;
   logic [63:0] fix_data = 64'hA5A5_0000_0000_0001;

   logic [63:0] q[$];
   logic [3:0]  m_op;
   bit          m_last_tx;
   bit          m_rxv;
   logic [63:0] m_rxd;
   int unsigned m_txc, m_rxc;

   always #5 clk = ~clk;

   nic_access_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .tx_valid    (tx_valid),
      .tx_data     (tx_data),
      .tx_ready    (tx_ready),
      .rx_valid    (rx_valid),
      .rx_data     (rx_data),
      .rx_ready    (rx_ready),
      .nic_en      (nic_en),
      .nic_wr_en   (nic_wr_en),
      .nic_addr    (nic_addr),
      .nic_d_in    (nic_d_in),
      .nic_d_out   (nic_d_out),
      .nic_buff_en (nic_buff_en),
      .busy        (busy)
`ifdef NIC_CTRL_STATS_EN
      ,
      .tx_cnt      (tx_cnt),
      .rx_cnt      (rx_cnt)
`endif
   );

   // behavioural NIC register file
   always_comb begin
      nic_d_out = in_data ^ 64'h5555_0000_0000_0000;
      case (nic_addr)
         2'b11:   nic_d_out = {in_data[63:1], out_busy};
         2'b01:   nic_d_out = {in_data[63:1], in_avail};
         2'b00:   nic_d_out = in_data;
         default: ;
      endcase
   end

   assign nic_buff_en = buff_acc && nic_en && nic_wr_en
                     && (nic_addr == 2'b10);

   task automatic chk(input string tag,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s act=%h exp=%h t=%0t",
                  tag, act, exp, $time);
      end
   endtask

   function automatic bit rnd(input int pct);
      return $urandom_range(99) < pct;
   endfunction

   task automatic model_reset();
      q.delete();
      m_op      = B_IDLE;
      m_last_tx = 1'b0;
      m_rxv     = 1'b0;
      m_rxd     = '0;
      m_txc     = 0;
      m_rxc     = 0;
   endtask

   task automatic drive();
      tx_valid = use_fix ? 1'b1 : rnd(p_txv);
      tx_data  = use_fix ? fix_data : {$urandom, $urandom};
      rx_ready = rnd(p_rdy);
      out_busy = rnd(p_busy);
      in_avail = rnd(p_avail);
      in_data  = {$urandom, $urandom};
      buff_acc = rnd(p_acc);
   endtask

   // compare this cycle, then advance the model
   task automatic check_step();
      int  sz;
      bit  tx_el, rx_el;
      logic [3:0]  nxt;
      logic [63:0] exp_din;
      sz = q.size();
      exp_din = (m_op == B_OWR && sz > 0) ? q[0] : 64'h0;
      chk("bus_op", {60'h0, nic_en, nic_wr_en, nic_addr},
          {60'h0, m_op});
      chk("d_in", nic_d_in, exp_din);
      chk("tx_ready", {63'h0, tx_ready}, {63'h0, sz < QD});
      chk("rx_valid", {63'h0, rx_valid}, {63'h0, m_rxv});
      chk("rx_data", rx_data, m_rxd);
      chk("busy", {63'h0, busy},
          {63'h0, (m_op != B_IDLE) || sz != 0 || m_rxv});
`ifdef NIC_CTRL_STATS_EN
      chk("tx_cnt", {32'h0, tx_cnt}, {32'h0, m_txc});
      chk("rx_cnt", {32'h0, rx_cnt}, {32'h0, m_rxc});
`endif
      tx_el = sz != 0;
      rx_el = !m_rxv;
      nxt   = B_IDLE;
      case (m_op)
         B_IDLE: begin
            if (tx_el && (!rx_el || !m_last_tx)) begin
               nxt = B_OSTAT;
               m_last_tx = 1'b1;
            end else if (rx_el) begin
               nxt = B_ISTAT;
               m_last_tx = 1'b0;
            end
         end
         B_OSTAT: nxt = out_busy ? B_IDLE : B_OWR;
         B_OWR: begin
            if (buff_acc && sz > 0) begin
               void'(q.pop_front());
               m_txc++;
            end
         end
         B_ISTAT: nxt = in_avail ? B_IRD : B_IDLE;
         default: ;
      endcase
      if (m_rxv && rx_ready) m_rxv = 1'b0;
      if (m_op == B_IRD) begin
         m_rxv = 1'b1;
         m_rxd = in_data;
         m_rxc++;
      end
      if (tx_valid && sz < QD) q.push_back(tx_data);
      m_op = nxt;
   endtask

   task automatic run(input int n, input int txv,
                      input int bsy, input int av,
                      input int acc, input int rdy);
      p_txv = txv; p_busy = bsy; p_avail = av;
      p_acc = acc; p_rdy = rdy;
      for (int i = 0; i < n; i++) begin
         drive();
         @(negedge clk);
         check_step();
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      bit found;
      reset    = 1'b1;
      tx_valid = 1'b0;
      tx_data  = '0;
      rx_ready = 1'b0;
      out_busy = 1'b0;
      in_avail = 1'b0;
      in_data  = '0;
      buff_acc = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_nic_en", {63'h0, nic_en}, 64'h0);
      chk("rst_rx_valid", {63'h0, rx_valid}, 64'h0);
      chk("rst_rx_data", rx_data, 64'h0);
      chk("rst_tx_ready", {63'h0, tx_ready}, 64'h1);
      chk("rst_busy", {63'h0, busy}, 64'h0);
      reset = 1'b0;

      use_fix = 1'b1;
      run(1, 100, 0, 0, 100, 100);
      use_fix = 1'b0;
      run(8, 0, 0, 0, 100, 100);

      run(1, 100, 100, 0, 100, 100);
      run(10, 0, 100, 0, 100, 100);
      run(8, 0, 0, 0, 100, 100);

      run(12, 0, 0, 100, 100, 0);
      run(6, 0, 0, 0, 100, 100);

      run(24, 100, 100, 0, 100, 100);
      run(24, 50, 0, 0, 100, 100);

      run(3000, 50, 30, 50, 70, 60);

      found = 1'b0;
      p_txv = 100; p_busy = 0; p_avail = 50;
      p_acc = 0; p_rdy = 50;
      for (int i = 0; i < 60 && !found; i++) begin
         drive();
         @(negedge clk);
         found = nic_en && nic_wr_en;
         check_step();
         if (!found) begin
            @(posedge clk);
            #1;
         end
      end
      chk("write_seen", {63'h0, found}, 64'h1);
      #2 reset = 1'b1;
      #1;
      chk("arst_nic_en", {63'h0, nic_en}, 64'h0);
      chk("arst_nic_wr", {63'h0, nic_wr_en}, 64'h0);
      chk("arst_addr", {62'h0, nic_addr}, 64'h0);
      chk("arst_d_in", nic_d_in, 64'h0);
      chk("arst_tx_ready", {63'h0, tx_ready}, 64'h1);
      chk("arst_rx_valid", {63'h0, rx_valid}, 64'h0);
      chk("arst_busy", {63'h0, busy}, 64'h0);
`ifdef NIC_CTRL_STATS_EN
      chk("arst_tx_cnt", {32'h0, tx_cnt}, 64'h0);
      chk("arst_rx_cnt", {32'h0, rx_cnt}, 64'h0);
`endif
      tx_valid = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();

      run(300, 50, 30, 50, 70, 60);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/nic_access_ctrl.md
Name: nic_access_ctrl

Overview:
- Sequencer that owns the NIC register port on behalf of a PE-side stream interface.
- TX: packets from a valid/ready stream are queued in a small FIFO, then written to the NIC output buffer after polling output status.
- RX: polls input status, reads the NIC input buffer, and presents the packet on a valid/ready stream.
- Sits between the PE datapath and the NIC. TX and RX turns are granted round-robin.

Parameters:
- DATA_W, 64, packet width; must equal the NIC data width.
- TXQ_DEPTH, 4, TX FIFO entries; power of two, ≥2.
- CNT_W, 32, statistics counter width (used only with NIC_CTRL_STATS_EN).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- tx_valid  in  1  PE has a packet to send
- tx_data  in  DATA_W  packet to send
- tx_ready  out  1  FIFO can accept; equals !full
- rx_valid  out  1  received packet held in rx_data
- rx_data  out  DATA_W  received packet
- rx_ready  in  1  PE consumes rx_data
- nic_en  out  1  NIC access enable
- nic_wr_en  out  1  NIC write (1) / read (0)
- nic_addr  out  2  NIC register: 00 input buffer, 01 input status, 10 output buffer, 11 output status
- nic_d_in  out  DATA_W  write data to the NIC
- nic_d_out  in  DATA_W  combinational read data from the NIC
- nic_buff_en  in  1  NIC accepted the output-buffer write this cycle
- busy  out  1  FSM not in S_IDLE, or FIFO not empty, or rx_valid high

Behaviour:
- Reset: FSM to S_IDLE; FIFO empty; rx_valid=0; rx_data=0; last_grant=RX, so TX wins the first tie.
- Reset is asynchronous and aborts any access. The NIC port outputs drop to 0 immediately.
- FIFO push: tx_valid && tx_ready.
  - tx_ready is low when full, so there is no push-at-full.
  - Push and pop in the same cycle leave the count unchanged.
- NIC port outputs are Moore-decoded from the state. In S_IDLE, nic_en, nic_wr_en, nic_addr and nic_d_in are all 0.
- S_IDLE eligibility: tx_elig = FIFO non-empty; rx_elig = !rx_valid.
  - Both eligible: pick the side opposite last_grant.
  - One eligible: pick that side.
  - Neither eligible: stay in S_IDLE.
  - Picking TX goes to S_POLL_OUT and sets last_grant=TX. Picking RX goes to S_POLL_IN and sets last_grant=RX.
- S_POLL_OUT: nic_en=1, wr=0, addr=11. If nic_d_out[0]==0, go to S_WRITE; else go to S_IDLE.
- S_WRITE: nic_en=1, wr=1, addr=10, nic_d_in=FIFO head.
  - If nic_buff_en: pop the FIFO, then go to S_IDLE.
  - Else: no pop, go to S_IDLE; the packet is retried later.
- S_POLL_IN: nic_en=1, wr=0, addr=01. If nic_d_out[0]==1, go to S_READ; else go to S_IDLE.
- S_READ: nic_en=1, wr=0, addr=00. Register rx_data<=nic_d_out, set rx_valid=1, go to S_IDLE.
- rx_valid clears on rx_valid && rx_ready. rx_data holds its value until the next S_READ.
- A NIC busy status always returns to S_IDLE, which hands the turn to the other side (no starvation).
- Minimum TX latency: push in cycle 0, S_IDLE decision in cycle 1, S_POLL_OUT in cycle 2, write strobe in cycle 3.
- Minimum RX latency: S_IDLE in cycle k, S_POLL_IN in k+1, S_READ in k+2, rx_valid=1 in k+3.
- FIFO pointers wrap modulo TXQ_DEPTH. Count width is clog2(TXQ_DEPTH)+1.

Optional Feature:
- Macro: NIC_CTRL_STATS_EN.
- When defined, two extra outputs exist:
  - tx_cnt[CNT_W-1:0]: increments on S_WRITE && nic_buff_en.
  - rx_cnt[CNT_W-1:0]: increments on S_READ.
  - Both reset to 0, wrap at 2^CNT_W, and do not saturate.
- When undefined, both ports and the counter logic are absent.

Decomposition:
- Package nic_pkg holds:
  - NIC address constants: NIC_ADDR_IN_BUF=2'b00, NIC_ADDR_IN_STAT=2'b01, NIC_ADDR_OUT_BUF=2'b10, NIC_ADDR_OUT_STAT=2'b11.
  - The FSM state encoding (S_IDLE, S_POLL_OUT, S_WRITE, S_POLL_IN, S_READ).
  - The DATA_W default.
- Sub-module nic_tx_fifo: synchronous FIFO with push/pop, full/empty and head data.

Test Plan:
- Reset, then push 0xA5A5_0000_0000_0001 with the NIC output status reading 0 → addr=10 write strobe exactly 3 cycles after the push, nic_d_in=0xA5A5_0000_0000_0001, FIFO empty afterwards.
- Output status held at 1 for 10 cycles with 1 packet queued → no addr=10 write strobe, packet retained. Release status → written on the next TX turn.
- Input status=1 with input buffer 0xDEAD_BEEF → rx_valid=1 and rx_data=0xDEAD_BEEF 3 cycles after S_IDLE. With rx_ready=0, no further addr=01/00 reads occur.
- Both sides eligible continuously → TX and RX turns alternate strictly, starting with TX after reset.
- Push 5 packets with TXQ_DEPTH=4 while the NIC is busy → tx_ready=0 after 4 pushes. The 5th is accepted only after the first pop, and packets exit in order.
- Assert reset during S_WRITE → NIC outputs 0 in the same cycle, FIFO empty, rx_valid=0, tx_cnt and rx_cnt=0 (when NIC_CTRL_STATS_EN is defined).
